// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder.
// funct3 codes, FSM states and the registered response bundle.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the core (master) and data memory (slave).
// Both directions use a valid/ready handshake.
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_func3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_func3, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_func3, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering for byte/half/word loads and stores.
// Offsets are always aligned down to the access size.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  func3,
    input  logic [31:0] wdata,
    input  logic [31:0] raw,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata
);

    logic        is_b;
    logic        is_h;
    logic        is_w;
    logic        sx;
    logic [7:0]  b;
    logic [15:0] h;

    assign is_b = (func3 == F3_B) || (func3 == F3_BU);
    assign is_h = (func3 == F3_H) || (func3 == F3_HU);
    assign is_w = (func3 == F3_W);
    assign sx   = ~func3[2];

    assign b = raw[{off, 3'b000} +: 8];
    assign h = off[1] ? raw[31:16] : raw[15:0];

    always_comb begin
        be       = '0;
        wdata_sh = '0;
        rdata    = '0;
        unique case (1'b1)
            is_b: begin
                be       = 4'b0001 << off;
                wdata_sh = {4{wdata[7:0]}};
                rdata    = {{24{sx & b[7]}}, b};
            end
            is_h: begin
                be       = off[1] ? 4'b1100 : 4'b0011;
                wdata_sh = {2{wdata[15:0]}};
                rdata    = {{16{sx & h[15]}}, h};
            end
            is_w: begin
                be       = 4'b1111;
                wdata_sh = wdata;
                rdata    = raw;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data memory with programmable wait states and sign/zero extension.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned half/word accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input logic              clk,
    input logic              reset,
    dmem_responder_if.slave  bus
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = $clog2(WAIT_STATES + 2);

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    rsp_t            rsp_q;

    logic            q_we;
    logic [31:0]     q_addr;
    logic [31:0]     q_wdata;
    logic [2:0]      q_f3;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            accept;
    logic            exec;
    logic            f3_ok;
    logic            in_range;
    logic            misalign;
    logic            err;
    logic [AW-1:0]   widx;
    logic [31:0]     raw;
    logic [3:0]      be;
    logic [31:0]     wdata_sh;
    logic [31:0]     ld_data;

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rsp_q.rdata;
    assign bus.rsp_err   = rsp_q.err;

    assign accept = bus.req_valid && bus.req_ready;
    assign exec   = (state == WAIT) && (cnt == '0);

    assign widx     = q_addr[AW+1:2];
    assign raw      = mem[widx];
    assign in_range = {2'b00, q_addr[31:2]} < 32'(DEPTH_WORDS);
    assign f3_ok    = q_we ? (q_f3 inside {F3_B, F3_H, F3_W})
                           : (q_f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = ((q_f3[1:0] == 2'b01) && q_addr[0]) ||
                      ((q_f3[1:0] == 2'b10) && (q_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign err = !f3_ok || !in_range || misalign;

    dmem_lane_align u_align (
        .off      (q_addr[1:0]),
        .func3    (q_f3),
        .wdata    (q_wdata),
        .raw      (raw),
        .be       (be),
        .wdata_sh (wdata_sh),
        .rdata    (ld_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = WAIT;
            WAIT: if (cnt == '0) state_nx = RESP;
            RESP: if (bus.rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            rsp_q <= '0;
        end else begin
            if (accept) begin
                cnt <= CW'(WAIT_STATES);
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (exec) begin
                rsp_q.err   <= err;
                rsp_q.rdata <= (err || q_we) ? '0 : ld_data;
            end
        end
    end

    // Capture and storage carry no reset; a reset in WAIT suppresses the write.
    always_ff @(posedge clk) begin
        if (accept) begin
            q_we    <= bus.req_we;
            q_addr  <= bus.req_addr;
            q_wdata <= bus.req_wdata;
            q_f3    <= bus.req_func3;
        end
        if (!reset && exec && q_we && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-array memory model.
// Honours DMEM_MISALIGN_TRAP_EN to select misaligned-access expectations.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int WS    = 1;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] mb [DEPTH*4];

    always #5 clk = ~clk;

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_STATES (WS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    function automatic void model(input logic we, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [2:0] f3,
                                  output logic [31:0] rd, output logic er);
        int     size;
        int     base;
        bit     legal;
        longint v;
        if (we) legal = (f3 <= 3'd2);
        else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        size = 1 << f3[1:0];
        er   = !legal || ((longint'(a) >> 2) >= DEPTH);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (legal && (longint'(a) % size != 0)) er = 1'b1;
`endif
        rd = '0;
        if (er) return;
        base = int'(a) / size * size;
        if (we) begin
            for (int i = 0; i < size; i++) mb[base+i] = wd[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < size; i++) v = v | (longint'(mb[base+i]) << (8*i));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | (~64'd0 << (8*size));
            rd = v[31:0];
        end
    endfunction

    task automatic do_txn(input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] f3,
                          output logic [31:0] rd, output logic er,
                          output int lat);
        int n;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_func3 = f3;
        bus.rsp_ready = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        checks++;
        if (!bus.rsp_valid) begin
            errors++;
            $display("FAIL txn_timeout: addr %h got no rsp_valid, required one", a);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp_valid: got %b required 0", bus.rsp_valid);
        end
        checks++;
        if (bus.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp_err: got %b required 0", bus.rsp_err);
        end
        checks++;
        if (bus.rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rsp_rdata: got %h required 0", bus.rsp_rdata);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready: got %b required 1", bus.req_ready);
        end
    endtask

    task automatic test_fill;
        logic [31:0] rd, erd, d;
        logic        er, eer;
        int          lat;
        for (int w = 0; w < DEPTH; w++) begin
            d = $urandom;
            model(1'b1, 32'(w*4), d, 3'b010, erd, eer);
            do_txn(1'b1, 32'(w*4), d, 3'b010, rd, er, lat);
            checks++;
            if (er !== eer || rd !== erd) begin
                errors++;
                $display("FAIL fill: word %0d got err %b rdata %h required err %b rdata %h",
                         w, er, rd, eer, erd);
            end
            checks++;
            if (lat !== WS + 1) begin
                errors++;
                $display("FAIL fill_latency: got %0d required %0d", lat, WS + 1);
            end
        end
    endtask

    task automatic test_directed;
        logic        t_we  [11];
        logic [31:0] t_a   [11];
        logic [31:0] t_wd  [11];
        logic [2:0]  t_f3  [11];
        logic [31:0] t_rd  [11];
        logic        t_er  [11];
        logic [31:0] rd, mrd;
        logic        er, mer;
        int          lat;
        t_we[0]=1; t_a[0]=32'h10;  t_wd[0]=32'hDEADBEEF; t_f3[0]=3'd2; t_rd[0]=0;            t_er[0]=0;
        t_we[1]=0; t_a[1]=32'h10;  t_wd[1]=0;            t_f3[1]=3'd2; t_rd[1]=32'hDEADBEEF; t_er[1]=0;
        t_we[2]=1; t_a[2]=32'h13;  t_wd[2]=32'h80;       t_f3[2]=3'd0; t_rd[2]=0;            t_er[2]=0;
        t_we[3]=0; t_a[3]=32'h13;  t_wd[3]=0;            t_f3[3]=3'd0; t_rd[3]=32'hFFFFFF80; t_er[3]=0;
        t_we[4]=0; t_a[4]=32'h13;  t_wd[4]=0;            t_f3[4]=3'd4; t_rd[4]=32'h00000080; t_er[4]=0;
        t_we[5]=0; t_a[5]=32'h10;  t_wd[5]=0;            t_f3[5]=3'd2; t_rd[5]=32'h80ADBEEF; t_er[5]=0;
        t_we[6]=0; t_a[6]=32'h400; t_wd[6]=0;            t_f3[6]=3'd2; t_rd[6]=0;            t_er[6]=1;
        t_we[7]=1; t_a[7]=32'h10;  t_wd[7]=32'h0;        t_f3[7]=3'd3; t_rd[7]=0;            t_er[7]=1;
        t_we[8]=0; t_a[8]=32'h10;  t_wd[8]=0;            t_f3[8]=3'd6; t_rd[8]=0;            t_er[8]=1;
`ifdef DMEM_MISALIGN_TRAP_EN
        t_we[9]=0;  t_a[9]=32'h11;  t_wd[9]=0;       t_f3[9]=3'd1;  t_rd[9]=0;             t_er[9]=1;
        t_we[10]=1; t_a[10]=32'h11; t_wd[10]=32'h1234; t_f3[10]=3'd1; t_rd[10]=0;          t_er[10]=1;
`else
        t_we[9]=0;  t_a[9]=32'h11;  t_wd[9]=0;       t_f3[9]=3'd1;  t_rd[9]=32'hFFFFBEEF;  t_er[9]=0;
        t_we[10]=1; t_a[10]=32'h11; t_wd[10]=32'h1234; t_f3[10]=3'd1; t_rd[10]=0;          t_er[10]=0;
`endif
        for (int i = 0; i < 11; i++) begin
            model(t_we[i], t_a[i], t_wd[i], t_f3[i], mrd, mer);
            do_txn(t_we[i], t_a[i], t_wd[i], t_f3[i], rd, er, lat);
            checks++;
            if (rd !== t_rd[i] || er !== t_er[i]) begin
                errors++;
                $display("FAIL directed_%0d: got err %b rdata %h required err %b rdata %h",
                         i, er, rd, t_er[i], t_rd[i]);
            end
            checks++;
            if (lat !== WS + 1) begin
                errors++;
                $display("FAIL directed_latency_%0d: got %0d required %0d", i, lat, WS + 1);
            end
        end
        do_txn(1'b0, 32'h10, 32'h0, 3'd2, rd, er, lat);
        checks++;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (rd !== 32'h80ADBEEF || er !== 1'b0) begin
            errors++;
            $display("FAIL misalign_store_effect: got %h required 80adbeef", rd);
        end
`else
        if (rd !== 32'h80AD1234 || er !== 1'b0) begin
            errors++;
            $display("FAIL misalign_store_effect: got %h required 80ad1234", rd);
        end
`endif
        model(1'b0, 32'h10, 32'h0, 3'd2, mrd, mer);
        model(1'b0, 32'h3FC, 32'h0, 3'd2, mrd, mer);
        do_txn(1'b0, 32'h3FC, 32'h0, 3'd2, rd, er, lat);
        checks++;
        if (rd !== mrd || er !== 1'b0) begin
            errors++;
            $display("FAIL last_word: got err %b rdata %h required err 0 rdata %h", er, rd, mrd);
        end
    endtask

    task automatic test_random;
        logic [31:0] a, wd, rd, mrd;
        logic [2:0]  f3;
        logic        we, er, mer;
        int          lat;
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom % 2);
            f3 = 3'($urandom % 8);
            wd = $urandom;
            if ($urandom % 16 == 0)     a = $urandom;
            else if ($urandom % 8 == 0) a = 32'h400 + 32'($urandom % 256);
            else                        a = 32'($urandom % (DEPTH*4));
            model(we, a, wd, f3, mrd, mer);
            do_txn(we, a, wd, f3, rd, er, lat);
            checks++;
            if (rd !== mrd || er !== mer) begin
                errors++;
                $display("FAIL random_%0d: we %b f3 %0d addr %h got err %b rdata %h required err %b rdata %h",
                         i, we, f3, a, er, rd, mer, mrd);
            end
        end
    endtask

    task automatic test_hold;
        logic [31:0] mrd, mrd2;
        logic        mer, mer2;
        int          n;
        model(1'b0, 32'h10, 32'h0, 3'd2, mrd, mer);
        model(1'b0, 32'h14, 32'h0, 3'd2, mrd2, mer2);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h10;
        bus.req_func3 = 3'd2;
        @(posedge clk);
        #1;
        bus.req_addr = 32'h14;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== mrd ||
                bus.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: got valid %b rdata %h req_ready %b required 1 %h 0",
                         c, bus.rsp_valid, bus.rsp_rdata, bus.req_ready, mrd);
            end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: got valid %b req_ready %b required 0 1",
                     bus.rsp_valid, bus.req_ready);
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== mrd2 || n !== WS + 1) begin
            errors++;
            $display("FAIL held_request: got valid %b rdata %h lat %0d required 1 %h %0d",
                     bus.rsp_valid, bus.rsp_rdata, n, mrd2, WS + 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        int acc[$];
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h10;
        bus.req_func3 = 3'd2;
        for (int c = 0; c < 17; c++) begin
            if (bus.req_ready) acc.push_back(c);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        checks++;
        if (acc.size() < 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d accepts required at least 4", acc.size());
        end
        for (int i = 1; i < acc.size(); i++) begin
            checks++;
            if (acc[i] - acc[i-1] !== WS + 3) begin
                errors++;
                $display("FAIL b2b_gap_%0d: got %0d required %0d", i, acc[i] - acc[i-1], WS + 3);
            end
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_wait;
        logic [31:0] rd, mrd;
        logic        er, mer;
        int          lat;
        model(1'b1, 32'h20, 32'hCAFEF00D, 3'd2, mrd, mer);
        do_txn(1'b1, 32'h20, 32'hCAFEF00D, 3'd2, rd, er, lat);
        for (int k = 0; k <= WS; k++) begin
            @(negedge clk);
            bus.rsp_ready = 1'b1;
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b1;
            bus.req_addr  = 32'h20;
            bus.req_wdata = 32'h12345678;
            bus.req_func3 = 3'd2;
            @(posedge clk);
            #1 bus.req_valid = 1'b0;
            repeat (k) @(posedge clk);
            #1 reset = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (bus.rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_wait_valid_%0d: got %b required 0", k, bus.rsp_valid);
            end
            reset = 1'b0;
            model(1'b0, 32'h20, 32'h0, 3'd2, mrd, mer);
            do_txn(1'b0, 32'h20, 32'h0, 3'd2, rd, er, lat);
            checks++;
            if (rd !== mrd || er !== 1'b0) begin
                errors++;
                $display("FAIL reset_wait_data_%0d: got %h required %h", k, rd, mrd);
            end
        end
    endtask

    task automatic test_reset_resp;
        int n;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h10;
        bus.req_func3 = 3'd2;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_resp: got valid %b req_ready %b rdata %h required 0 1 0",
                     bus.rsp_valid, bus.req_ready, bus.rsp_rdata);
        end
        reset         = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_func3 = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_fill();
        test_directed();
        test_random();
        test_hold();
        test_back_to_back();
        test_reset_wait();
        test_reset_resp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
